// File: rtl/l2_arbiter.sv
// Shared L2 line-port arbiter between the I-cache miss port and the D-cache miss/writeback port.
// One owner at a time; ties alternate using the last completed owner.
module l2_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              I_read,
  input  logic [ADDR_W-1:0] I_address,
  output logic [LINE_W-1:0] I_rdata,
  output logic              I_resp,

  input  logic              D_read,
  input  logic              D_write,
  input  logic [ADDR_W-1:0] D_address,
  input  logic [LINE_W-1:0] D_wdata,
  output logic [LINE_W-1:0] D_rdata,
  output logic              D_resp,

  output logic              L2_read,
  output logic              L2_write,
  output logic [ADDR_W-1:0] L2_address,
  output logic [LINE_W-1:0] L2_wdata,
  input  logic [LINE_W-1:0] L2_rdata,
  input  logic              L2_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;
  logic   last_grant;   // 0 = I owned the last transaction, 1 = D
  logic   i_req;
  logic   d_req;
  logic   grant;
  logic   grant_d;
  logic   done;

  assign i_req = I_read;
  assign d_req = D_read | D_write;

  // Next-state selection; a tie goes to the side that did not own the last transaction.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          state_nx = last_grant ? SERVE_I : SERVE_D;
        end else if (d_req) begin
          state_nx = SERVE_D;
        end else if (i_req) begin
          state_nx = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (L2_resp) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign grant   = (state == IDLE) && (state_nx != IDLE);
  assign grant_d = (state_nx == SERVE_D);
  assign done    = (state != IDLE) && L2_resp;

  // State, ownership history and the latched request that drives the L2 port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      L2_read    <= 1'b0;
      L2_write   <= 1'b0;
      L2_address <= '0;
      L2_wdata   <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        L2_address <= grant_d ? D_address : I_address;
        if (grant_d) begin
          L2_wdata <= D_wdata;
        end
        // Simultaneous D read+write is illegal; the write is honoured.
        L2_write <= grant_d & D_write;
        L2_read  <= ~(grant_d & D_write);
      end else if (done) begin
        L2_read    <= 1'b0;
        L2_write   <= 1'b0;
        last_grant <= (state == SERVE_D);
      end
    end
  end

  // Completion is steered to the owner in the L2_resp cycle itself.
  assign I_resp  = (state == SERVE_I) & L2_resp;
  assign D_resp  = (state == SERVE_D) & L2_resp;
  assign I_rdata = L2_rdata;
  assign D_rdata = L2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: expected transactions are queued when requests are raised
// and checked against the L2 port and response pulses as each transaction is served.
module tb_l2_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LINE_W = 128;

  logic              clk;
  logic              rst_n;
  logic              I_read;
  logic [ADDR_W-1:0] I_address;
  logic [LINE_W-1:0] I_rdata;
  logic              I_resp;
  logic              D_read;
  logic              D_write;
  logic [ADDR_W-1:0] D_address;
  logic [LINE_W-1:0] D_wdata;
  logic [LINE_W-1:0] D_rdata;
  logic              D_resp;
  logic              L2_read;
  logic              L2_write;
  logic [ADDR_W-1:0] L2_address;
  logic [LINE_W-1:0] L2_wdata;
  logic [LINE_W-1:0] L2_rdata;
  logic              L2_resp;

  l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .I_read     (I_read),
    .I_address  (I_address),
    .I_rdata    (I_rdata),
    .I_resp     (I_resp),
    .D_read     (D_read),
    .D_write    (D_write),
    .D_address  (D_address),
    .D_wdata    (D_wdata),
    .D_rdata    (D_rdata),
    .D_resp     (D_resp),
    .L2_read    (L2_read),
    .L2_write   (L2_write),
    .L2_address (L2_address),
    .L2_wdata   (L2_wdata),
    .L2_rdata   (L2_rdata),
    .L2_resp    (L2_resp)
  );

  typedef struct packed {
    logic              owner;  // 0 = I, 1 = D
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic owner, input logic wr,
                               input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] wd);
    exp_t e;
    e.owner = owner;
    e.wr    = wr;
    e.addr  = a;
    e.wdata = wd;
    sb.push_back(e);
  endfunction

  // Serve the next expected transaction: wait for grant, hold for lat cycles, respond, return in IDLE.
  task automatic serve(input int lat, input logic [LINE_W-1:0] rd,
                       input logic chg, input logic [ADDR_W-1:0] chg_addr);
    exp_t e;
    int   n;
    chk("sb_nonempty", LINE_W'(sb.size() != 0), LINE_W'(1));
    if (sb.size() == 0) return;
    e = sb.pop_front();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(L2_read || L2_write) && n < 20);
    chk("grant_lat", LINE_W'(n), LINE_W'(1));
    chk("l2_addr", LINE_W'(L2_address), LINE_W'(e.addr));
    chk("l2_write", LINE_W'(L2_write), LINE_W'(e.wr));
    chk("l2_read", LINE_W'(L2_read), LINE_W'(!e.wr));
    if (e.wr) chk("l2_wdata", L2_wdata, e.wdata);
    for (int i = 1; i < lat; i++) begin
      if (chg && i == 1) D_address = chg_addr;
      @(negedge clk);
      chk("addr_stable", LINE_W'(L2_address), LINE_W'(e.addr));
      chk("op_stable", LINE_W'({L2_read, L2_write}), LINE_W'({!e.wr, e.wr}));
      if (e.wr) chk("wdata_stable", L2_wdata, e.wdata);
      chk("early_resp", LINE_W'({I_resp, D_resp}), LINE_W'(0));
    end
    L2_rdata = rd;
    L2_resp  = 1'b1;
    #1;
    if (e.owner) begin
      chk("d_resp", LINE_W'(D_resp), LINE_W'(1));
      chk("i_resp_nonowner", LINE_W'(I_resp), LINE_W'(0));
      if (!e.wr) chk("d_rdata", D_rdata, rd);
    end else begin
      chk("i_resp", LINE_W'(I_resp), LINE_W'(1));
      chk("d_resp_nonowner", LINE_W'(D_resp), LINE_W'(0));
      chk("i_rdata", I_rdata, rd);
    end
    @(negedge clk);
    chk("idle_l2_ops", LINE_W'({L2_read, L2_write}), LINE_W'(0));
    // L2_resp still high here: must be ignored in IDLE, and resp pulses only one cycle.
    chk("resp_one_cycle", LINE_W'({I_resp, D_resp}), LINE_W'(0));
    L2_resp  = 1'b0;
    L2_rdata = {4{$urandom}};
    if (e.owner) begin
      D_read  = 1'b0;
      D_write = 1'b0;
    end else begin
      I_read = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [LINE_W-1:0] pat;
    rst_n     = 1'b0;
    I_read    = 1'b0;
    I_address = '0;
    D_read    = 1'b0;
    D_write   = 1'b0;
    D_address = '0;
    D_wdata   = '0;
    L2_rdata  = '0;
    L2_resp   = 1'b0;
    #1;
    chk("rst_ops", LINE_W'({L2_read, L2_write, I_resp, D_resp}), LINE_W'(0));
    chk("rst_addr", LINE_W'(L2_address), LINE_W'(0));
    chk("rst_wdata", L2_wdata, LINE_W'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Tie after reset: D first, then I; immediate re-request alternates back to D.
    I_read = 1'b1; I_address = 16'h1110;
    D_read = 1'b1; D_address = 16'h3330;
    push(1'b1, 1'b0, 16'h3330, '0);
    push(1'b0, 1'b0, 16'h1110, '0);
    serve(2, {4{32'h0D0D_0001}}, 1'b0, '0);
    serve(1, {4{32'h1111_0002}}, 1'b0, '0);
    I_read = 1'b1; I_address = 16'h1120;
    D_read = 1'b1; D_address = 16'h3340;
    push(1'b1, 1'b0, 16'h3340, '0);
    push(1'b0, 1'b0, 16'h1120, '0);
    serve(1, {4{32'h0D0D_0003}}, 1'b0, '0);
    serve(2, {4{32'h1111_0004}}, 1'b0, '0);

    // I-only read with a 3-cycle L2 latency.
    I_read = 1'b1; I_address = 16'h1230;
    push(1'b0, 1'b0, 16'h1230, '0);
    serve(3, {32'hDEAD_0000, 64'h0123_4567_89AB_CDEF, 32'h0000_BEEF}, 1'b0, '0);

    // D writeback.
    pat = {16{8'hA5}};
    D_write = 1'b1; D_address = 16'h4440; D_wdata = pat;
    push(1'b1, 1'b1, 16'h4440, pat);
    serve(3, '0, 1'b0, '0);

    // Operand stability: address and data change mid-transaction must not leak out.
    pat = {4{32'hC0FF_EE11}};
    D_read = 1'b1; D_address = 16'h4440; D_wdata = pat;
    push(1'b1, 1'b0, 16'h4440, '0);
    serve(4, {4{32'h5A5A_0005}}, 1'b1, 16'h7770);

    // Protocol violation: read and write together becomes a write.
    pat = {4{$urandom}};
    D_read = 1'b1; D_write = 1'b1; D_address = 16'h6660; D_wdata = pat;
    push(1'b1, 1'b1, 16'h6660, pat);
    serve(2, '0, 1'b0, '0);

    // Async reset mid-SERVE_I, then a tie that must go to D.
    I_read = 1'b1; I_address = 16'h2220;
    @(negedge clk);
    chk("pre_rst_read", LINE_W'(L2_read), LINE_W'(1));
    chk("pre_rst_addr", LINE_W'(L2_address), LINE_W'(16'h2220));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ops", LINE_W'({L2_read, L2_write}), LINE_W'(0));
    chk("async_rst_addr", LINE_W'(L2_address), LINE_W'(0));
    chk("async_rst_wdata", L2_wdata, LINE_W'(0));
    L2_resp = 1'b1;
    #0.1;
    chk("async_rst_resp", LINE_W'({I_resp, D_resp}), LINE_W'(0));
    L2_resp = 1'b0;
    D_read = 1'b1; D_address = 16'h5550;
    push(1'b1, 1'b0, 16'h5550, '0);
    push(1'b0, 1'b0, 16'h2220, '0);
    #0.5 rst_n = 1'b1;
    serve(2, {4{32'h7777_0006}}, 1'b0, '0);
    serve(1, {4{32'h8888_0007}}, 1'b0, '0);

    @(negedge clk);
    chk("final_idle", LINE_W'({L2_read, L2_write}), LINE_W'(0));
    chk("sb_drained", LINE_W'(sb.size()), LINE_W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Arbitrates between the instruction-cache miss port (I, read-only) and the data-cache miss/writeback port (D, read/write) for the single shared L2/physical-memory line port. It grants one requester at a time and holds that grant until L2 responds. It captures the granted request, routes the response back to the owner, and alternates grants when both sides are waiting. It sits in `mp3` between the two L1 caches and the L2 interface.

## Interface
- `ADDR_W`, default 16: line address width, matches `lc3b_word`.
- `LINE_W`, default 128: cache line width in bits.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `I_read` in 1: I-cache line read request, level, held until `I_resp`.
- `I_address` in ADDR_W: I-cache line address.
- `I_rdata` out LINE_W: line data returned to I-cache.
- `I_resp` out 1: one-cycle completion pulse to I-cache.
- `D_read` in 1: D-cache line read request, held until `D_resp`.
- `D_write` in 1: D-cache line writeback request, held until `D_resp`.
- `D_address` in ADDR_W: D-cache line address.
- `D_wdata` in LINE_W: writeback line data.
- `D_rdata` out LINE_W: line data returned to D-cache.
- `D_resp` out 1: one-cycle completion pulse to D-cache.
- `L2_read` out 1: read request to L2.
- `L2_write` out 1: write request to L2.
- `L2_address` out ADDR_W: registered request address.
- `L2_wdata` out LINE_W: registered write data.
- `L2_rdata` in LINE_W: read data from L2.
- `L2_resp` in 1: L2 completion, one cycle.

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D. A 1-bit `last_grant` register records the last owner (0 = I, 1 = D).
- IDLE, I pending only: go to SERVE_I. D pending only (`D_read|D_write`): go to SERVE_D.
- IDLE, both pending: grant the side not equal to `last_grant`. After reset `last_grant` = I, so D wins the first tie.
- On a grant edge, latch into internal registers:
  - the granted address;
  - `D_wdata` (for D grants);
  - the operation bit (write if `D_write`, else read).
- If `D_read` and `D_write` are both high, that is a protocol violation. Write wins.
- SERVE_x drives `L2_read` or `L2_write` from the latched operation bit. `L2_address` and `L2_wdata` come from the latched registers and stay stable for the whole transaction. Requester input changes during SERVE are ignored.
- SERVE_x with `L2_resp`=1:
  - the owner's `*_resp` = 1 in the same cycle (combinational);
  - the next state is IDLE;
  - `last_grant` is updated to the owner.
- `I_rdata` and `D_rdata` are both wired to `L2_rdata`. They are valid only with the corresponding `*_resp`.
- The non-owner's resp is never asserted. `L2_resp` seen in IDLE is ignored.
- If a requester drops its request mid-transaction (illegal), the L2 transaction still completes and resp still pulses.
- Reset (async, any state): state = IDLE, `last_grant` = I, latched address/data/op = 0.

## Timing
- Reset values:
  - `L2_read`, `L2_write`, `I_resp`, `D_resp` = 0;
  - `L2_address` = 0, `L2_wdata` = 0.
  - All take effect immediately on `rst_n` low, without waiting for a clock edge.
- Grant latency: a request visible in IDLE before edge k causes `L2_read`/`L2_write` high from edge k.
- `L2_read`/`L2_write` fall on the edge after the `L2_resp` cycle.
- There is exactly one IDLE cycle between consecutive transactions. During that cycle requesters drop their just-satisfied request, so a stale request is never re-granted.
- Minimum transaction is 2 cycles: the SERVE cycle with `L2_resp`, then IDLE.
- L2 outputs are never both high. Both are 0 in IDLE.

## Test plan
- I-only read: `I_read`=1, addr 0x1230; L2 responds 3 cycles later with 0xDEAD...BEEF.
  - Expect `L2_read`=1 and `L2_address`=0x1230 from the first edge.
  - Expect `I_resp`=1 and `I_rdata`=data in the resp cycle.
  - Expect `D_resp`=0 throughout.
- D writeback: `D_write`=1, addr 0x4440, data 0xA5 repeated. Expect `L2_write`=1 and `L2_wdata` stable until `L2_resp`, then `D_resp`=1 for one cycle.
- Tie after reset: I and D request in the same cycle.
  - Expect D served first, then IDLE, then I served.
  - Both re-request immediately: expect D served next (round-robin).
- Operand stability: change `D_address` from 0x4440 to 0x7770 mid-SERVE_D. Expect `L2_address` to stay 0x4440.
- Async reset mid-SERVE_I: pulse `rst_n` low between edges.
  - Expect `L2_read`=0 immediately and state IDLE.
  - A subsequent tie grants D.
- Protocol violation: `D_read`=`D_write`=1. Expect a write transaction, and `L2_read` never asserted.
